// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared CPU pipeline definitions: hazard-controller state encoding, default
// timing and the bundle of pipeline-register enable/bubble controls.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W      = 5;
  localparam int MD_LAT_DEF = 4;
  localparam int CNT_W_DEF  = 32;
  localparam int MD_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_HALTED  = 2'd2
  } hz_state_e;

  // Enables and bubbles of the PC and pipeline registers, packed MSB first.
  typedef struct packed {
    logic en_pc;
    logic en_ifid;
    logic en_idex;
    logic en_exmem;
    logic en_memwb;
    logic bb_ifid;
    logic bb_idex;
    logic bb_exmem;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN   = 8'b11111_000;
  localparam pipe_ctrl_t CTRL_STALL = 8'b00011_010;
  localparam pipe_ctrl_t CTRL_FLUSH = 8'b10011_110;
  localparam pipe_ctrl_t CTRL_MD    = 8'b00001_001;
  localparam pipe_ctrl_t CTRL_OFF   = 8'b00000_000;
  localparam pipe_ctrl_t CTRL_RST   = 8'b00000_111;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID/EX hazard inputs and pipeline control outputs of the hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = pipeline_hazard_ctrl_pkg::CNT_W_DEF
);
  import pipeline_hazard_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] ex_wbreg;
  logic             ex_memtoreg;
  logic             ex_regwrite;
  logic             ex_branch_taken;
  logic             ex_md_start;
  logic             ex_halt;

  logic             en_pc;
  logic             en_ifid;
  logic             en_idex;
  logic             en_exmem;
  logic             en_memwb;
  logic             bb_ifid;
  logic             bb_idex;
  logic             bb_exmem;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_wbreg, ex_memtoreg,
           ex_regwrite, ex_branch_taken, ex_md_start, ex_halt,
    input  en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           bb_ifid, bb_idex, bb_exmem, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_wbreg, ex_memtoreg,
           ex_regwrite, ex_branch_taken, ex_md_start, ex_halt,
    output en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           bb_ifid, bb_idex, bb_exmem, halted, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction
// reads. Register 0 is hardwired, so a load to $0 never creates a hazard.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic [REG_W-1:0] ex_wbreg_i,
  input  logic             ex_memtoreg_i,
  input  logic             ex_regwrite_i,
  output logic             load_use_o
);

  logic rs_hit;
  logic rt_hit;

  // Compare both source operands against the pending load destination.
  always_comb begin
    rs_hit     = id_use_rs_i & (id_rs_i == ex_wbreg_i);
    rt_hit     = id_use_rt_i & (id_rt_i == ex_wbreg_i);
    load_use_o = ex_memtoreg_i & ex_regwrite_i & (ex_wbreg_i != '0) & (rs_hit | rt_hit);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, multi-cycle
// mul/div freeze and halt, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_MAX = '1;

  hz_state_e            state_q, state_d;
  logic [MD_CNT_W-1:0]  md_cnt_q, md_cnt_d;
  logic                 br_pend_q, br_pend_d;
  logic                 drain_q, drain_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
  pipe_ctrl_t           ctrl;
  pipe_ctrl_t           ctrl_out;
  logic                 flush_now;
  logic                 branch_eff;
  logic                 load_use;

  hazard_detect u_hazard_detect (
    .id_rs_i       (hz.id_rs),
    .id_rt_i       (hz.id_rt),
    .id_use_rs_i   (hz.id_use_rs),
    .id_use_rt_i   (hz.id_use_rt),
    .ex_wbreg_i    (hz.ex_wbreg),
    .ex_memtoreg_i (hz.ex_memtoreg),
    .ex_regwrite_i (hz.ex_regwrite),
    .load_use_o    (load_use)
  );

  // A branch that arrived together with a mul/div is replayed on freeze exit.
  assign branch_eff = hz.ex_branch_taken | br_pend_q;

  // Next-state and pipeline control decode; halt > mul/div > branch > load-use.
  always_comb begin
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    br_pend_d = br_pend_q;
    drain_d   = 1'b0;
    ctrl      = CTRL_RUN;
    flush_now = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hz.ex_halt) begin
          state_d   = ST_HALTED;
          drain_d   = 1'b1;
          br_pend_d = 1'b0;
        end else if (hz.ex_md_start) begin
          state_d   = ST_MD_BUSY;
          md_cnt_d  = MD_LOAD;
          br_pend_d = branch_eff;
          ctrl      = CTRL_MD;
        end else if (branch_eff) begin
          br_pend_d = 1'b0;
          flush_now = 1'b1;
          ctrl      = CTRL_FLUSH;
        end else begin
          br_pend_d = 1'b0;
          if (load_use) begin
            ctrl = CTRL_STALL;
          end
        end
      end
      ST_MD_BUSY: begin
        ctrl     = CTRL_MD;
        md_cnt_d = md_cnt_q - 1'b1;
        if (md_cnt_q == MD_CNT_W'(1)) begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        ctrl          = CTRL_OFF;
        ctrl.en_memwb = drain_q;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Saturating counters; the halted pipeline is not counted as stalled.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ctrl.en_pc && (state_q != ST_HALTED) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (flush_now && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  // State, freeze timer, deferred branch and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      md_cnt_q    <= '0;
      br_pend_q   <= 1'b0;
      drain_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      br_pend_q   <= br_pend_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // While reset is held every stage is frozen and bubbled.
  always_comb begin
    ctrl_out = rst ? CTRL_RST : ctrl;
  end

  assign hz.en_pc     = ctrl_out.en_pc;
  assign hz.en_ifid   = ctrl_out.en_ifid;
  assign hz.en_idex   = ctrl_out.en_idex;
  assign hz.en_exmem  = ctrl_out.en_exmem;
  assign hz.en_memwb  = ctrl_out.en_memwb;
  assign hz.bb_ifid   = ctrl_out.bb_ifid;
  assign hz.bb_idex   = ctrl_out.bb_idex;
  assign hz.bb_exmem  = ctrl_out.bb_exmem;
  assign hz.halted    = ~rst & (state_q == ST_HALTED);
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule
